branch_predict_resolve: RTL and testbench
=========================================

// Module: branch_predict_resolve
// PURPOSE
//  Branch resolution plus a direct-mapped branch target buffer (BTB) with saturating direction counters.
//  - Fetch: looks up PC_F and supplies a predicted next PC.
//  - Execute: resolves BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR against the flags.
//  - Issues a redirect and flush only on mispredict, and trains the table.
//  - Keeps branch and mispredict statistics counters.
// PARAMETERS
//  ADDR_WIDTH  32  PC / target width
//  ENTRIES     16  BTB entries; power of 2, >=2; IDX=$clog2(ENTRIES)
//  CTR_BITS    2   direction counter width; taken when MSB=1
// PORTS
//  clk              in   1           clock, rising edge
//  rst              in   1           asynchronous reset, active-high
//  PC_F             in   ADDR_WIDTH  fetch PC
//  PredTaken_F      out  1           BTB hit and counter MSB=1
//  PredTarget_F     out  ADDR_WIDTH  stored target; 0 when PredTaken_F=0
//  Valid_E          in   1           EX holds a real, unstalled instruction
//  PC_E             in   ADDR_WIDTH  EX instruction PC
//  opcode_E         in   7           EX opcode
//  func3_E          in   3           EX func3
//  ZeroFlag         in   1           ALU result == 0
//  NegativeFlag     in   1           signed rs1 < rs2
//  UnsignedLess     in   1           unsigned rs1 < rs2
//  Target_E         in   ADDR_WIDTH  computed branch/jump target
//  PredTaken_E      in   1           PredTaken_F piped to EX
//  PredTarget_E     in   ADDR_WIDTH  PredTarget_F piped to EX
//  PCSrc            out  2           00 none; 01 to Target_E (branch); 10 to PC_E+4; 11 to Target_E (jump)
//  Flush            out  1           kill IF/ID; equals (PCSrc!=00)
//  BranchCount      out  32          resolved branches/jumps, wraps
//  MispredictCount  out  32          redirects issued, wraps
// BEHAVIOUR
//  Reset
//  - All BTB valid bits are 0, both stats counters are 0, and PCSrc=00.
//  - Tags, targets and direction counters are not reset; they are qualified by valid.
//  Fetch lookup (combinational, 0 cycles)
//  - idx = PC_F[IDX+1:2]; tag = PC_F[ADDR_WIDTH-1:IDX+2].
//  - Hit = valid[idx] && tag match.
//  Resolution (combinational in EX; active only when Valid_E=1)
//  - Branch (opcode 1100011) taken when:
//    - 000 Z; 001 !Z; 100 N; 101 !N; 110 U; 111 !U.
//  - Any other func3 is not taken and is not a branch: no train, no count.
//  - JAL 1101111 and JALR 1100111 are always taken.
//  Redirect (combinational in EX)
//  - Correct = (taken==PredTaken_E) && (!taken || Target_E==PredTarget_E).
//  - Correct gives PCSrc=00.
//  - Mispredict with taken=1 gives PCSrc=01 for a branch, 11 for a jump.
//  - Mispredict with taken=0 gives PCSrc=10 (recover to PC_E+4).
//  - Valid_E=0 or a non-control op gives PCSrc=00, Flush=0.
//  Training (registered at the rising edge of clk, when Valid_E and a control op)
//  - Hit: write target=Target_E when taken; the counter moves up when taken, down when not taken.
//  - The counter saturates at 2^CTR_BITS-1 and 0.
//  - Miss and taken: allocate valid=1, tag, target, counter=10..0 (weakly taken).
//  - Miss and not taken: no write.
//  - Stats: BranchCount++ per control op; MispredictCount++ when PCSrc!=00.
//  Boundary conditions
//  - Same-cycle fetch read and EX write to one index: fetch sees the pre-write contents.
//  - Aliasing on idx: the entry is overwritten; no replacement policy.
//  - rst asserted mid-operation clears the table immediately, and subsequent lookups miss.
//  - Counters wrap modulo 2^32.
// STRUCTURE
//  - branch_pkg: opcode constants (OP_BRANCH, OP_JAL, OP_JALR), func3 constants, pcsrc_e enum {PCS_NONE, PCS_BRANCH, PCS_SEQ, PCS_JUMP}.
//  - Sub-module btb_table: the storage array with 1 combinational read port, 1 write port and the valid-bit async clear.
//  - Resolution, redirect and stats logic live in the top module.
// TESTING
//  1. Reset, then PC_F=0x100 -> PredTaken_F=0, PredTarget_F=0, BranchCount=0.
//  2. BEQ at 0x100, Z=1, Target_E=0x140, PredTaken_E=0
//     -> PCSrc=01, Flush=1, MispredictCount=1, entry allocated.
//     Next PC_F=0x100 -> PredTaken_F=1, PredTarget_F=0x140.
//  3. Same BEQ resolved not taken twice with correct pipes
//     -> 1st: PCSrc=10, counter 10->01; 2nd: PCSrc=00, counter 01->00, PredTaken_F=0.
//  4. BLTU N=1,U=0, then BGEU U=0 -> not taken then taken.
//     func3=010 -> PCSrc=00, no count.
//  5. JALR predicted 0x200, actual Target_E=0x204 -> PCSrc=11, target updated to 0x204.
//     Repeat -> PCSrc=00.
//  6. Same-cycle read/write to idx 3 -> fetch gets old data.
//     rst pulse mid-stream -> next lookup misses.
//     Counter saturation at 11 holds after 3 taken.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared opcode/func3 constants and the redirect-select encoding used by
// the branch resolution unit and its BTB.
package branch_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        PCS_NONE   = 2'b00,
        PCS_BRANCH = 2'b01,
        PCS_SEQ    = 2'b10,
        PCS_JUMP   = 2'b11
    } pcsrc_e;

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB storage: one combinational lookup port for fetch and one
// training port that does its own hit check and counter update.
module btb_table #(
    parameter int ADDR_WIDTH = 32,
    parameter int ENTRIES    = 16,
    parameter int CTR_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_rd_pc,
    output logic                  o_rd_hit,
    output logic                  o_rd_ctr_msb,
    output logic [ADDR_WIDTH-1:0] o_rd_target,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_pc,
    input  logic                  i_wr_taken,
    input  logic [ADDR_WIDTH-1:0] i_wr_target
);
    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_WIDTH - IDX - 2;

    logic [ENTRIES-1:0]    r_valid;
    logic [TAG_W-1:0]      r_tag    [ENTRIES];
    logic [ADDR_WIDTH-1:0] r_target [ENTRIES];
    logic [CTR_BITS-1:0]   r_ctr    [ENTRIES];

    logic [IDX-1:0]      w_rd_idx, w_wr_idx;
    logic [TAG_W-1:0]    w_rd_tag, w_wr_tag;
    logic                w_wr_hit, w_wr_write;
    logic [CTR_BITS-1:0] w_ctr_cur, w_ctr_next, w_ctr_weak;
    logic                w_unused_bits;

    assign w_rd_idx = i_rd_pc[IDX+1:2];
    assign w_rd_tag = i_rd_pc[ADDR_WIDTH-1:IDX+2];
    assign w_wr_idx = i_wr_pc[IDX+1:2];
    assign w_wr_tag = i_wr_pc[ADDR_WIDTH-1:IDX+2];
    assign w_unused_bits = ^{i_rd_pc[1:0], i_wr_pc[1:0]};

    assign o_rd_hit     = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
    assign o_rd_ctr_msb = r_ctr[w_rd_idx][CTR_BITS-1];
    assign o_rd_target  = r_target[w_rd_idx];

    assign w_wr_hit   = r_valid[w_wr_idx] && (r_tag[w_wr_idx] == w_wr_tag);
    assign w_wr_write = i_wr_en && (w_wr_hit || i_wr_taken);
    assign w_ctr_cur  = r_ctr[w_wr_idx];

    always_comb begin
        w_ctr_weak = '0;
        w_ctr_weak[CTR_BITS-1] = 1'b1;
        w_ctr_next = w_ctr_cur;
        if (!w_wr_hit)
            w_ctr_next = w_ctr_weak;
        else if (i_wr_taken && (w_ctr_cur != '1))
            w_ctr_next = w_ctr_cur + 1'b1;
        else if (!i_wr_taken && (w_ctr_cur != '0))
            w_ctr_next = w_ctr_cur - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_valid <= '0;
        else if (w_wr_write)
            r_valid[w_wr_idx] <= 1'b1;
    end

    // Payload is qualified by r_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_wr_write) begin
            r_tag[w_wr_idx] <= w_wr_tag;
            r_ctr[w_wr_idx] <= w_ctr_next;
            if (i_wr_taken)
                r_target[w_wr_idx] <= i_wr_target;
        end
    end

endmodule

// File: rtl/branch_predict_resolve.sv
// Branch/jump resolution in EX with mispredict redirect, BTB training and
// resolution statistics; fetch-side prediction comes from btb_table.
module branch_predict_resolve
    import branch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int ENTRIES    = 16,
    parameter int CTR_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] PC_F,
    output logic                  PredTaken_F,
    output logic [ADDR_WIDTH-1:0] PredTarget_F,
    input  logic                  Valid_E,
    input  logic [ADDR_WIDTH-1:0] PC_E,
    input  logic [6:0]            opcode_E,
    input  logic [2:0]            func3_E,
    input  logic                  ZeroFlag,
    input  logic                  NegativeFlag,
    input  logic                  UnsignedLess,
    input  logic [ADDR_WIDTH-1:0] Target_E,
    input  logic                  PredTaken_E,
    input  logic [ADDR_WIDTH-1:0] PredTarget_E,
    output logic [1:0]            PCSrc,
    output logic                  Flush,
    output logic [31:0]           BranchCount,
    output logic [31:0]           MispredictCount
);
    logic                  w_rd_hit, w_rd_msb;
    logic [ADDR_WIDTH-1:0] w_rd_target;
    logic                  w_is_branch, w_br_taken, w_is_jump;
    logic                  w_ctrl, w_taken, w_correct;
    pcsrc_e                w_pcsrc;
    logic [31:0]           r_branch_count, r_mispredict_count;

    btb_table #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ENTRIES    (ENTRIES),
        .CTR_BITS   (CTR_BITS)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .i_rd_pc     (PC_F),
        .o_rd_hit    (w_rd_hit),
        .o_rd_ctr_msb(w_rd_msb),
        .o_rd_target (w_rd_target),
        .i_wr_en     (w_ctrl),
        .i_wr_pc     (PC_E),
        .i_wr_taken  (w_taken),
        .i_wr_target (Target_E)
    );

    assign PredTaken_F  = w_rd_hit && w_rd_msb;
    assign PredTarget_F = PredTaken_F ? w_rd_target : '0;

    // Unlisted func3 values under the branch opcode are treated as non-control.
    always_comb begin
        w_is_branch = 1'b0;
        w_br_taken  = 1'b0;
        if (opcode_E == OP_BRANCH) begin
            w_is_branch = 1'b1;
            case (func3_E)
                F3_BEQ:  w_br_taken = ZeroFlag;
                F3_BNE:  w_br_taken = !ZeroFlag;
                F3_BLT:  w_br_taken = NegativeFlag;
                F3_BGE:  w_br_taken = !NegativeFlag;
                F3_BLTU: w_br_taken = UnsignedLess;
                F3_BGEU: w_br_taken = !UnsignedLess;
                default: w_is_branch = 1'b0;
            endcase
        end
    end

    assign w_is_jump = (opcode_E == OP_JAL) || (opcode_E == OP_JALR);
    assign w_ctrl    = Valid_E && (w_is_branch || w_is_jump);
    assign w_taken   = w_is_jump || w_br_taken;
    assign w_correct = (w_taken == PredTaken_E) && (!w_taken || (Target_E == PredTarget_E));

    always_comb begin
        w_pcsrc = PCS_NONE;
        if (w_ctrl && !w_correct) begin
            if (!w_taken)
                w_pcsrc = PCS_SEQ;
            else if (w_is_jump)
                w_pcsrc = PCS_JUMP;
            else
                w_pcsrc = PCS_BRANCH;
        end
    end

    assign PCSrc = w_pcsrc;
    assign Flush = (w_pcsrc != PCS_NONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (w_ctrl)
                r_branch_count <= r_branch_count + 32'd1;
            if (w_pcsrc != PCS_NONE)
                r_mispredict_count <= r_mispredict_count + 32'd1;
        end
    end

    assign BranchCount     = r_branch_count;
    assign MispredictCount = r_mispredict_count;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed vector table for the documented scenarios, a reset-mid-stream
// sequence, then random traffic against a behavioural BTB/resolution model.
module tb_branch_predict_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC_F;
    logic        PredTaken_F;
    logic [31:0] PredTarget_F;
    logic        Valid_E;
    logic [31:0] PC_E;
    logic [6:0]  opcode_E;
    logic [2:0]  func3_E;
    logic        ZeroFlag, NegativeFlag, UnsignedLess;
    logic [31:0] Target_E;
    logic        PredTaken_E;
    logic [31:0] PredTarget_E;
    logic [1:0]  PCSrc;
    logic        Flush;
    logic [31:0] BranchCount, MispredictCount;

    always #5 clk = ~clk;

    branch_predict_resolve dut (
        .clk(clk), .rst(rst), .PC_F(PC_F), .PredTaken_F(PredTaken_F),
        .PredTarget_F(PredTarget_F), .Valid_E(Valid_E), .PC_E(PC_E),
        .opcode_E(opcode_E), .func3_E(func3_E), .ZeroFlag(ZeroFlag),
        .NegativeFlag(NegativeFlag), .UnsignedLess(UnsignedLess),
        .Target_E(Target_E), .PredTaken_E(PredTaken_E), .PredTarget_E(PredTarget_E),
        .PCSrc(PCSrc), .Flush(Flush), .BranchCount(BranchCount),
        .MispredictCount(MispredictCount)
    );

    localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, ALU = 7'b0110011;

    typedef struct {
        logic [31:0] pc_f;  logic valid; logic [31:0] pc_e; logic [6:0] op; logic [2:0] f3;
        logic z, n, u;      logic [31:0] tgt; logic pt; logic [31:0] ptgt;
        logic [1:0] e_pcsrc; logic e_pre_pt; logic [31:0] e_pre_tgt;
        logic e_post_pt;    logic [31:0] e_post_tgt; int e_bc; int e_mc;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [31:0] pc_f, logic valid, logic [31:0] pc_e, logic [6:0] op,
                                logic [2:0] f3, logic z, logic n, logic u, logic [31:0] tgt,
                                logic pt, logic [31:0] ptgt, logic [1:0] e_pcsrc,
                                logic e_pre_pt, logic [31:0] e_pre_tgt, logic e_post_pt,
                                logic [31:0] e_post_tgt, int e_bc, int e_mc);
        vec_t v;
        v.pc_f = pc_f; v.valid = valid; v.pc_e = pc_e; v.op = op; v.f3 = f3;
        v.z = z; v.n = n; v.u = u; v.tgt = tgt; v.pt = pt; v.ptgt = ptgt;
        v.e_pcsrc = e_pcsrc; v.e_pre_pt = e_pre_pt; v.e_pre_tgt = e_pre_tgt;
        v.e_post_pt = e_post_pt; v.e_post_tgt = e_post_tgt; v.e_bc = e_bc; v.e_mc = e_mc;
        return v;
    endfunction

    task automatic drive(logic [31:0] pc_f, logic valid, logic [31:0] pc_e, logic [6:0] op,
                         logic [2:0] f3, logic z, logic n, logic u, logic [31:0] tgt,
                         logic pt, logic [31:0] ptgt);
        PC_F = pc_f; Valid_E = valid; PC_E = pc_e; opcode_E = op; func3_E = f3;
        ZeroFlag = z; NegativeFlag = n; UnsignedLess = u; Target_E = tgt;
        PredTaken_E = pt; PredTarget_E = ptgt;
    endtask

    // Behavioural model: entry remembers the PC that owns it; strength 0..3, taken when >=2.
    bit          m_valid [16];
    logic [31:0] m_pc    [16];
    logic [31:0] m_tgt   [16];
    int          m_str   [16];
    int          m_bc, m_mc;

    function automatic void m_lookup(input logic [31:0] pc, output bit pt, output logic [31:0] tgt);
        int i = int'((pc >> 2) % 16);
        bit hit = m_valid[i] && ((m_pc[i] >> 6) == (pc >> 6));
        pt  = hit && (m_str[i] >= 2);
        tgt = pt ? m_tgt[i] : 32'd0;
    endfunction

    logic [31:0] r_vals [5] = '{32'd0, 32'd1, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000};

    initial begin
        rst = 1'b1;
        drive(32'h100, 1'b0, 32'h0, 7'h0, 3'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        //        pc_f     v  pc_e     op    f3 z n u tgt      pt ptgt     pcs  pre        post       bc  mc
        vecs.push_back(mk(32'h100, 0, 32'h000, 7'h0, 0, 0,0,0, 32'h000, 0, 32'h000, 2'b00, 0,32'h000, 0,32'h000, 0, 0));
        vecs.push_back(mk(32'h100, 1, 32'h100, BR,   0, 1,0,0, 32'h140, 0, 32'h000, 2'b01, 0,32'h000, 1,32'h140, 1, 1));
        vecs.push_back(mk(32'h100, 1, 32'h100, BR,   0, 0,0,0, 32'h140, 1, 32'h140, 2'b10, 1,32'h140, 0,32'h000, 2, 2));
        vecs.push_back(mk(32'h100, 1, 32'h100, BR,   0, 0,0,0, 32'h140, 0, 32'h000, 2'b00, 0,32'h000, 0,32'h000, 3, 2));
        vecs.push_back(mk(32'h104, 1, 32'h104, BR,   6, 0,1,0, 32'h180, 0, 32'h000, 2'b00, 0,32'h000, 0,32'h000, 4, 2));
        vecs.push_back(mk(32'h104, 1, 32'h104, BR,   7, 0,0,0, 32'h180, 0, 32'h000, 2'b01, 0,32'h000, 1,32'h180, 5, 3));
        vecs.push_back(mk(32'h104, 1, 32'h104, BR,   2, 1,0,0, 32'h999, 0, 32'h000, 2'b00, 1,32'h180, 1,32'h180, 5, 3));
        vecs.push_back(mk(32'h108, 1, 32'h108, JALR, 0, 0,0,0, 32'h204, 1, 32'h200, 2'b11, 0,32'h000, 1,32'h204, 6, 4));
        vecs.push_back(mk(32'h108, 1, 32'h108, JALR, 0, 0,0,0, 32'h204, 1, 32'h204, 2'b00, 1,32'h204, 1,32'h204, 7, 4));
        vecs.push_back(mk(32'h108, 1, 32'h108, JAL,  0, 0,0,0, 32'h204, 1, 32'h204, 2'b00, 1,32'h204, 1,32'h204, 8, 4));
        vecs.push_back(mk(32'h108, 1, 32'h108, BR,   0, 0,0,0, 32'h204, 1, 32'h204, 2'b10, 1,32'h204, 1,32'h204, 9, 5));
        vecs.push_back(mk(32'h10C, 1, 32'h10C, BR,   0, 1,0,0, 32'h1C0, 0, 32'h000, 2'b01, 0,32'h000, 1,32'h1C0, 10, 6));
        vecs.push_back(mk(32'h10C, 1, 32'h10C, BR,   1, 1,0,0, 32'h1C0, 1, 32'h1C0, 2'b10, 1,32'h1C0, 0,32'h000, 11, 7));
        vecs.push_back(mk(32'h50C, 1, 32'h50C, JAL,  0, 0,0,0, 32'h300, 0, 32'h000, 2'b11, 0,32'h000, 1,32'h300, 12, 8));
        vecs.push_back(mk(32'h10C, 0, 32'h000, 7'h0, 0, 0,0,0, 32'h000, 0, 32'h000, 2'b00, 0,32'h000, 0,32'h000, 12, 8));
        vecs.push_back(mk(32'h110, 0, 32'h110, JAL,  0, 0,0,0, 32'h500, 0, 32'h000, 2'b00, 0,32'h000, 0,32'h000, 12, 8));
        vecs.push_back(mk(32'h108, 1, 32'h108, ALU,  0, 1,1,1, 32'h040, 1, 32'h040, 2'b00, 1,32'h204, 1,32'h204, 12, 8));
        vecs.push_back(mk(32'h114, 1, 32'h114, BR,   4, 0,1,0, 32'h400, 1, 32'h400, 2'b00, 0,32'h000, 1,32'h400, 13, 8));
        vecs.push_back(mk(32'h114, 1, 32'h114, BR,   5, 0,1,0, 32'h400, 1, 32'h400, 2'b10, 1,32'h400, 0,32'h000, 14, 9));
        vecs.push_back(mk(32'h114, 1, 32'h114, BR,   0, 1,0,0, 32'h440, 1, 32'h400, 2'b01, 0,32'h000, 1,32'h440, 15, 10));

        repeat (3) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].pc_f, vecs[i].valid, vecs[i].pc_e, vecs[i].op, vecs[i].f3,
                  vecs[i].z, vecs[i].n, vecs[i].u, vecs[i].tgt, vecs[i].pt, vecs[i].ptgt);
            #1;
            chk($sformatf("v%0d PCSrc", i), 64'(PCSrc), 64'(vecs[i].e_pcsrc));
            chk($sformatf("v%0d Flush", i), 64'(Flush), 64'(vecs[i].e_pcsrc != 2'b00));
            chk($sformatf("v%0d pre PredTaken_F", i), 64'(PredTaken_F), 64'(vecs[i].e_pre_pt));
            chk($sformatf("v%0d pre PredTarget_F", i), 64'(PredTarget_F), 64'(vecs[i].e_pre_tgt));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d post PredTaken_F", i), 64'(PredTaken_F), 64'(vecs[i].e_post_pt));
            chk($sformatf("v%0d post PredTarget_F", i), 64'(PredTarget_F), 64'(vecs[i].e_post_tgt));
            chk($sformatf("v%0d BranchCount", i), 64'(BranchCount), 64'(vecs[i].e_bc));
            chk($sformatf("v%0d MispredictCount", i), 64'(MispredictCount), 64'(vecs[i].e_mc));
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a cycle must clear the table at once.
        drive(32'h108, 1'b0, 32'h0, 7'h0, 3'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("rst pre hit", 64'(PredTaken_F), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst PredTaken_F", 64'(PredTaken_F), 64'd0);
        chk("rst PredTarget_F", 64'(PredTarget_F), 64'd0);
        chk("rst BranchCount", 64'(BranchCount), 64'd0);
        chk("rst MispredictCount", 64'(MispredictCount), 64'd0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("after rst lookup miss", 64'(PredTaken_F), 64'd0);
        @(negedge clk);

        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_bc = 0;
        m_mc = 0;

        for (int cyc = 0; cyc < 600; cyc++) begin
            logic [31:0] rs1, rs2, pce, pcf, tgt, ptgt, ftgt;
            logic [6:0]  op;
            logic [2:0]  f3;
            logic        valid, pt, ctrl, is_jump, taken, correct, fpt;
            int          sel, exp_pcsrc, ei;
            bit          hit;

            rs1 = r_vals[$urandom_range(0, 4)];
            rs2 = r_vals[$urandom_range(0, 4)];
            pce = 32'h1000 + ($urandom_range(0, 23) << 2) + ($urandom_range(0, 1) << 8);
            pcf = 32'h1000 + ($urandom_range(0, 23) << 2) + ($urandom_range(0, 1) << 8);
            tgt = 32'h2000 + ($urandom_range(0, 3) << 2);
            sel = int'($urandom_range(0, 7));
            op  = (sel < 4) ? BR : (sel == 4) ? JAL : (sel == 5) ? JALR : (sel == 6) ? ALU : 7'h13;
            f3  = 3'($urandom_range(0, 7));
            valid = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) < 7) begin
                m_lookup(pce, fpt, ftgt);
                pt = fpt;
                ptgt = ftgt;
            end else begin
                pt = 1'($urandom_range(0, 1));
                ptgt = pt ? 32'h2000 + ($urandom_range(0, 3) << 2) : 32'd0;
            end

            is_jump = (op == JAL) || (op == JALR);
            ctrl = valid && (is_jump || (op == BR && f3 != 3'd2 && f3 != 3'd3));
            case (f3)
                3'd0:    taken = (rs1 == rs2);
                3'd1:    taken = (rs1 != rs2);
                3'd4:    taken = ($signed(rs1) <  $signed(rs2));
                3'd5:    taken = ($signed(rs1) >= $signed(rs2));
                3'd6:    taken = (rs1 <  rs2);
                3'd7:    taken = (rs1 >= rs2);
                default: taken = 1'b0;
            endcase
            if (is_jump) taken = 1'b1;
            correct = (taken == pt) && (!taken || tgt == ptgt);
            if (!ctrl || correct) exp_pcsrc = 0;
            else if (!taken)      exp_pcsrc = 2;
            else                  exp_pcsrc = is_jump ? 3 : 1;

            drive(pcf, valid, pce, op, f3, rs1 == rs2, $signed(rs1) < $signed(rs2), rs1 < rs2,
                  tgt, pt, ptgt);
            m_lookup(pcf, fpt, ftgt);
            #1;
            chk($sformatf("rnd%0d PCSrc", cyc), 64'(PCSrc), 64'(exp_pcsrc));
            chk($sformatf("rnd%0d Flush", cyc), 64'(Flush), 64'(exp_pcsrc != 0));
            chk($sformatf("rnd%0d PredTaken_F", cyc), 64'(PredTaken_F), 64'(fpt));
            chk($sformatf("rnd%0d PredTarget_F", cyc), 64'(PredTarget_F), 64'(ftgt));

            if (ctrl) begin
                ei  = int'((pce >> 2) % 16);
                hit = m_valid[ei] && ((m_pc[ei] >> 6) == (pce >> 6));
                if (hit) begin
                    if (taken) begin
                        m_tgt[ei] = tgt;
                        m_str[ei] = (m_str[ei] < 3) ? m_str[ei] + 1 : 3;
                    end else begin
                        m_str[ei] = (m_str[ei] > 0) ? m_str[ei] - 1 : 0;
                    end
                end else if (taken) begin
                    m_valid[ei] = 1'b1;
                    m_pc[ei]    = pce;
                    m_tgt[ei]   = tgt;
                    m_str[ei]   = 2;
                end
                m_bc++;
            end
            if (exp_pcsrc != 0) m_mc++;

            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d BranchCount", cyc), 64'(BranchCount), 64'(m_bc));
            chk($sformatf("rnd%0d MispredictCount", cyc), 64'(MispredictCount), 64'(m_mc));
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
